// File: rtl/wall_depth_bar_sprite.sv
// Depth bar HUD / game-over screen pixel generator, 2-cycle pixel latency.
// Optional tick marks on the bar: define WALL_BAR_TICKS_EN.
module wall_depth_bar_sprite #(
  parameter int          SCREEN_WIDTH  = 1280,
  parameter int          SCREEN_HEIGHT = 720,
  parameter int          BAR_X         = 40,
  parameter int          BAR_Y         = 40,
  parameter int          BAR_WIDTH     = 50,
  parameter int          BAR_HEIGHT    = 640,
  parameter int          FILL_STEP     = 4,
  parameter logic [23:0] FILL_COLOR    = 24'h00C0FF,
  parameter logic [23:0] BAR_BG_COLOR  = 24'h202020,
  parameter logic [23:0] SCREEN_COLOR  = 24'h800000,
  parameter int          FLASH_PERIOD  = 8,
  parameter int          FLASH_COUNT   = 3,
  parameter int          TICK_SPACING  = 64
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        new_frame_in,
  input  logic [9:0]  depth_in,
  input  logic        game_over_in,
  input  logic        restart_in,
  output logic [23:0] pixel_out,
  output logic        settled_out,
  output logic        over_out
);

  localparam logic [11:0] SW  = 12'(SCREEN_WIDTH);
  localparam logic [11:0] SH  = 12'(SCREEN_HEIGHT);
  localparam logic [11:0] BX0 = 12'(BAR_X);
  localparam logic [11:0] BX1 = 12'(BAR_X + BAR_WIDTH);
  localparam logic [11:0] BY0 = 12'(BAR_Y);
  localparam logic [11:0] BY1 = 12'(BAR_Y + BAR_HEIGHT);
  localparam logic [11:0] GX0 = 12'(SCREEN_WIDTH * 45 / 100);
  localparam logic [11:0] GX1 = 12'(SCREEN_WIDTH * 55 / 100);
  localparam logic [11:0] GX2 = 12'(SCREEN_WIDTH * 75 / 100);
  localparam logic [11:0] GY0 = 12'(SCREEN_HEIGHT * 25 / 100);
  localparam logic [11:0] GY1 = 12'(SCREEN_HEIGHT * 75 / 100);
  localparam logic [11:0] GY2 = 12'(SCREEN_HEIGHT * 60 / 100);
  localparam logic [9:0]  BH  = 10'(BAR_HEIGHT);
  localparam logic [9:0]  STP = 10'(FILL_STEP);
  localparam logic [7:0]  FC_LAST = 8'(FLASH_PERIOD - 1);
  localparam logic [7:0]  N_LAST  = 8'(2 * FLASH_COUNT - 1);

  typedef enum logic [1:0] {RUN, FLASH, OVER} state_t;

  state_t     state, state_nx;
  logic [9:0] fill, fill_nx;
  logic [9:0] tgt, tgt_nx;
  logic [7:0] fc, fc_nx;
  logic [7:0] n, n_nx;
  logic       ph_off, ph_off_nx;
  logic [9:0] depth_c;

  assign depth_c = (depth_in > BH) ? BH : depth_in;

  function automatic logic [9:0] approach(input logic [9:0] cur,
                                          input logic [9:0] t);
    if (t > cur)
      return (t - cur <= STP) ? t : cur + STP;
    else
      return (cur - t <= STP) ? t : cur - STP;
  endfunction

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state       <= RUN;
      fill        <= '0;
      tgt         <= '0;
      fc          <= '0;
      n           <= '0;
      ph_off      <= 1'b0;
      settled_out <= 1'b1;
      over_out    <= 1'b0;
    end else begin
      state       <= state_nx;
      fill        <= fill_nx;
      tgt         <= tgt_nx;
      fc          <= fc_nx;
      n           <= n_nx;
      ph_off      <= ph_off_nx;
      settled_out <= (fill == tgt);
      over_out    <= (state == OVER);
    end
  end

  always_comb begin
    state_nx  = state;
    fill_nx   = fill;
    tgt_nx    = tgt;
    fc_nx     = fc;
    n_nx      = n;
    ph_off_nx = ph_off;
    unique case (state)
      RUN: begin
        // game over beats restart, but this frame's fill step still lands
        if (game_over_in) begin
          if (new_frame_in) begin
            tgt_nx  = depth_c;
            fill_nx = approach(fill, depth_c);
          end
          state_nx  = FLASH;
          fc_nx     = '0;
          n_nx      = '0;
          ph_off_nx = 1'b0;
        end else if (restart_in) begin
          fill_nx = '0;
          tgt_nx  = '0;
        end else if (new_frame_in) begin
          tgt_nx  = depth_c;
          fill_nx = approach(fill, depth_c);
        end
      end
      FLASH: begin
        if (new_frame_in) begin
          if (fc == FC_LAST) begin
            fc_nx     = '0;
            ph_off_nx = ~ph_off;
            n_nx      = n + 8'd1;
            if (n == N_LAST) state_nx = OVER;
          end else begin
            fc_nx = fc + 8'd1;
          end
        end
      end
      OVER: begin
        if (restart_in) begin
          state_nx  = RUN;
          fill_nx   = '0;
          tgt_nx    = '0;
          fc_nx     = '0;
          n_nx      = '0;
          ph_off_nx = 1'b0;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  logic [11:0] h, v, fill_row;
  logic        in_screen_d, in_bar_d, filled_d, glyph_d, tick_d;

  assign h        = {1'b0, hcount_in};
  assign v        = {2'b0, vcount_in};
  assign fill_row = BY1 - {2'b0, fill};

  assign in_screen_d = (h < SW) && (v < SH);
  assign in_bar_d    = (h >= BX0) && (h < BX1) && (v >= BY0) && (v < BY1);
  assign filled_d    = (v >= fill_row);
  assign glyph_d     = ((h > GX0) && (h < GX1) && (v > GY0) && (v < GY1)) ||
                       ((h > GX0) && (h < GX2) && (v > GY2) && (v < GY1));

`ifdef WALL_BAR_TICKS_EN
  localparam logic [11:0] TMASK = 12'(TICK_SPACING - 1);
  assign tick_d = (((BY1 - 12'd1 - v) & TMASK) == 12'd0);
`else
  logic unused_tick_cfg;
  assign unused_tick_cfg = ^TICK_SPACING;
  assign tick_d = 1'b0;
`endif

  logic   s1_in_screen, s1_in_bar, s1_filled, s1_glyph, s1_tick;
  logic   s1_ph_off;
  state_t s1_state;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      s1_in_screen <= 1'b0;
      s1_in_bar    <= 1'b0;
      s1_filled    <= 1'b0;
      s1_glyph     <= 1'b0;
      s1_tick      <= 1'b0;
      s1_ph_off    <= 1'b0;
      s1_state     <= RUN;
    end else begin
      s1_in_screen <= in_screen_d;
      s1_in_bar    <= in_bar_d;
      s1_filled    <= filled_d;
      s1_glyph     <= glyph_d;
      s1_tick      <= tick_d;
      s1_ph_off    <= ph_off;
      s1_state     <= state;
    end
  end

  logic [23:0] color;

  always_comb begin
    color = 24'h000000;
    if (!s1_in_screen) begin
      color = 24'h000000;
    end else if (s1_state == OVER) begin
      color = s1_glyph ? 24'hFFFFFF : SCREEN_COLOR;
    end else if (s1_in_bar) begin
      if (s1_tick)
        color = 24'h404040;
      else if (!s1_filled)
        color = BAR_BG_COLOR;
      else if (s1_state == FLASH && !s1_ph_off)
        color = 24'hFFFFFF;
      else
        color = FILL_COLOR;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) pixel_out <= '0;
    else           pixel_out <= color;
  end

endmodule

// File: tb/tb_wall_depth_bar_sprite.sv
// Bench for wall_depth_bar_sprite: frame-level model plus directed pixels.
module tb_wall_depth_bar_sprite;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic        nf, go, rs;
  logic [9:0]  depth;
  logic [23:0] px;
  logic        settled, over;

  always #5 clk = ~clk;

  wall_depth_bar_sprite dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .hcount_in    (hc),
    .vcount_in    (vc),
    .new_frame_in (nf),
    .depth_in     (depth),
    .game_over_in (go),
    .restart_in   (rs),
    .pixel_out    (px),
    .settled_out  (settled),
    .over_out     (over)
  );

  int checks   = 0;
  int failures = 0;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] FILLC = 24'h00C0FF;
  localparam logic [23:0] BGC   = 24'h202020;
  localparam logic [23:0] SCRC  = 24'h800000;

  // model: 0 RUN, 1 FLASH, 2 OVER; frames = frame pulses seen in FLASH
  int          m_state, m_fill, m_tgt, m_frames;
  logic [23:0] e1, e2;
  logic        m_settled, m_over;
  bit          chk_en = 0;

  function automatic logic [23:0] model_px(int h, int v, int st,
                                           int fl, int fr);
    bit in_bar;
    if (h >= 1280 || v >= 720) return 24'h0;
    if (st == 2) begin
      if ((h > 576 && h < 704 && v > 180 && v < 540) ||
          (h > 576 && h < 960 && v > 432 && v < 540))
        return WHITE;
      return SCRC;
    end
    in_bar = (h >= 40 && h < 90 && v >= 40 && v < 680);
    if (!in_bar) return 24'h0;
`ifdef WALL_BAR_TICKS_EN
    if (((679 - v) % 64) == 0) return 24'h404040;
`endif
    if (v < 680 - fl) return BGC;
    if (st == 1 && ((fr / 8) % 2) == 0) return WHITE;
    return FILLC;
  endfunction

  function automatic int step_toward(int cur, int t);
    if (t - cur > 4) return cur + 4;
    if (cur - t > 4) return cur - 4;
    return t;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = 0; m_fill = 0; m_tgt = 0; m_frames = 0;
      e1 = 0; e2 = 0; m_settled = 1; m_over = 0;
    end else begin
      e2 = e1;
      e1 = model_px(int'(hc), int'(vc), m_state, m_fill, m_frames);
      m_settled = (m_fill == m_tgt);
      m_over    = (m_state == 2);
      case (m_state)
        0: begin
          if (go) begin
            if (nf) begin
              m_tgt  = (depth > 640) ? 640 : int'(depth);
              m_fill = step_toward(m_fill, m_tgt);
            end
            m_state = 1; m_frames = 0;
          end else if (rs) begin
            m_fill = 0; m_tgt = 0;
          end else if (nf) begin
            m_tgt  = (depth > 640) ? 640 : int'(depth);
            m_fill = step_toward(m_fill, m_tgt);
          end
        end
        1: if (nf) begin
          m_frames++;
          if (m_frames == 48) m_state = 2;
        end
        default: if (rs) begin
          m_state = 0; m_fill = 0; m_tgt = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (px !== e2) begin
        failures++;
        $display("FAIL cyc_pixel got=%h want=%h", px, e2);
      end
      checks++;
      if (settled !== m_settled) begin
        failures++;
        $display("FAIL cyc_settled got=%b want=%b", settled, m_settled);
      end
      checks++;
      if (over !== m_over) begin
        failures++;
        $display("FAIL cyc_over got=%b want=%b", over, m_over);
      end
    end
  end

  task automatic rnd_hv();
    hc = 11'($urandom_range(0, 1300));
    vc = 10'($urandom_range(0, 730));
  endtask

  task automatic pulse(bit f, bit g, bit r);
    @(negedge clk);
    nf = f; go = g; rs = r;
    rnd_hv();
    @(negedge clk);
    nf = 0; go = 0; rs = 0;
    rnd_hv();
    @(negedge clk);
    rnd_hv();
  endtask

  task automatic frame();
    pulse(1, 0, 0);
  endtask

  task automatic expect_px(int h, int v, logic [23:0] exp, string name);
    @(negedge clk);
    hc = 11'(h); vc = 10'(v);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (px !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, px, exp);
    end
  endtask

  task automatic expect_bit(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic expect_fill(string name, int exp);
    checks++;
    if (m_fill != exp) begin
      failures++;
      $display("FAIL %s model_fill=%0d want=%0d", name, m_fill, exp);
    end
  endtask

  initial begin
    rst_n = 0; nf = 0; go = 0; rs = 0; depth = 0; hc = 0; vc = 0;
    @(posedge clk);
    chk_en = 1;
    repeat (3) @(negedge clk);
    expect_bit("rst_settled", settled, 1'b1);
    expect_bit("rst_over", over, 1'b0);
    checks++;
    if (px !== 24'h0) begin
      failures++;
      $display("FAIL rst_pixel got=%h want=000000", px);
    end
    rst_n = 1;
    expect_px(40, 679, BGC, "rst_bg");

    depth = 10;
    frame(); expect_fill("ramp1", 4);
    expect_bit("ramp1_settled", settled, 1'b0);
    frame(); expect_fill("ramp2", 8);
    frame(); expect_fill("ramp3", 10);
    expect_bit("ramp3_settled", settled, 1'b1);
    expect_px(60, 670, FILLC, "ramp_filled");
    expect_px(60, 669, BGC, "ramp_bg");

    depth = 1000;
    repeat (200) frame();
    expect_fill("clamp", 640);
    expect_px(45, 40, FILLC, "clamp_top");
`ifdef WALL_BAR_TICKS_EN
    expect_px(45, 679, 24'h404040, "tick_679");
    expect_px(45, 678, FILLC, "tick_678");
`endif
    depth = 0;
    frame(); expect_fill("down1", 636);
    expect_px(45, 43, BGC, "down_bg");
    expect_px(45, 44, FILLC, "down_fill");
    depth = 100;
    repeat (140) frame();
    expect_fill("to100", 100);

    pulse(0, 1, 0);
    for (int i = 0; i < 48; i++) begin
      expect_px(45, 670, (((i / 8) % 2) == 0) ? WHITE : FILLC, "flash");
      if (i == 47) expect_bit("pre_over", over, 1'b0);
      frame();
    end
    expect_bit("over_set", over, 1'b1);
    expect_px(640, 500, WHITE, "glyph");
    expect_px(100, 100, SCRC, "over_bg");
    expect_px(1279, 719, SCRC, "over_corner");
    pulse(0, 1, 1);
    expect_bit("over_restart", over, 1'b0);
    expect_fill("over_restart_fill", 0);
    expect_px(45, 670, BGC, "restart_bg");

    depth = 20;
    repeat (5) frame();
    pulse(0, 1, 1);
    expect_fill("go_rs_fill", 20);
    expect_px(45, 670, WHITE, "go_rs_flash");
    pulse(0, 0, 1);
    expect_px(45, 670, WHITE, "flash_rs_ignored");
    @(negedge clk) rst_n = 0;
    @(negedge clk) rst_n = 1;
    expect_px(45, 670, BGC, "mid_flash_reset");
    expect_bit("reset_over", over, 1'b0);

    depth = 8;
    pulse(1, 1, 0);
    expect_fill("go_nf_fill", 4);
    expect_px(45, 676, WHITE, "go_nf_on");
    expect_px(45, 675, BGC, "go_nf_bg");
    repeat (48) frame();
    expect_bit("over2", over, 1'b1);
    pulse(0, 0, 1);
    expect_fill("over2_restart", 0);

    expect_px(1280, 0, 24'h0, "bound_h");
    expect_px(0, 720, 24'h0, "bound_v");
    expect_px(1279, 719, 24'h0, "run_black");
    repeat (3) begin
      rnd_hv();
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wall_depth_bar_sprite.md
# wall_depth_bar_sprite

Parametrised, pipelined pixel generator for the wall-depth HUD and game-over screen. Draws a vertical depth bar that fills from the bottom and animates toward a target depth once per frame. On game over it flashes the bar for a fixed number of frames, then switches to a full game-over screen with a white glyph until restart. Sits in the pixel path beside the other sprites; its output feeds the compositor.

## Interface
- SCREEN_WIDTH, 1280, active pixels per line
- SCREEN_HEIGHT, 720, active lines
- BAR_X, 40, left column of bar
- BAR_Y, 40, top row of bar
- BAR_WIDTH, 50, bar width in pixels
- BAR_HEIGHT, 640, bar height in pixels; max fill
- FILL_STEP, 4, max fill change (pixels) per frame
- FILL_COLOR, 24'h00C0FF, filled bar colour
- BAR_BG_COLOR, 24'h202020, unfilled bar colour
- SCREEN_COLOR, 24'h800000, game-over background
- FLASH_PERIOD, 8, frames per flash half-period
- FLASH_COUNT, 3, flash on/off cycles before game-over screen
- TICK_SPACING, 64, tick pitch in pixels (see Configuration)

Ports:
- clk_in  input  1  pixel clock
- rst_n_in  input  1  synchronous reset, active-low
- hcount_in  input  11  current column
- vcount_in  input  10  current row
- new_frame_in  input  1  one-cycle pulse, once per frame (start of vblank)
- depth_in  input  10  target fill in pixels; sampled on new_frame_in
- game_over_in  input  1  one-cycle pulse
- restart_in  input  1  one-cycle pulse
- pixel_out  output  24  RGB pixel
- settled_out  output  1  high when displayed fill equals clamped target
- over_out  output  1  high in state OVER

## Operation
- Target: tgt = min(depth_in, BAR_HEIGHT), latched on new_frame_in in RUN only.
- Fill register fill (10 bit) updated on new_frame_in in RUN: if |tgt−fill| ≤ FILL_STEP then fill=tgt, else fill moves FILL_STEP toward tgt. Frozen in FLASH and OVER.
- A bar pixel is filled when vcount ≥ BAR_Y+BAR_HEIGHT−fill. fill=0 means empty; fill=BAR_HEIGHT means full.
- FSM:
  - RUN: bar drawn, all else 24'h000000. game_over_in → FLASH. restart_in → fill=0, tgt=0.
  - FLASH: frame counter fc and flash counter n. Each new_frame_in increments fc. At fc=FLASH_PERIOD−1, fc clears and phase toggles. After 2·FLASH_COUNT toggles → OVER. Filled pixels are 24'hFFFFFF in the "on" phase and FILL_COLOR in the "off" phase; the first phase is "on".
  - OVER: whole screen SCREEN_COLOR. White glyph where (0.45W<h<0.55W and 0.25H<v<0.75H) or (0.45W<h<0.75W and 0.60H<v<0.75H). Bounds are integer constants computed at elaboration and truncated. restart_in → RUN, fill=0, tgt=0, counters cleared.
- Simultaneous events:
  - game_over_in and restart_in in RUN: game_over wins; fill is not cleared.
  - Both in OVER: restart wins.
  - game_over_in with new_frame_in in RUN: the fill update for that frame applies, then FLASH.
  - game_over_in in FLASH/OVER is ignored. restart_in in FLASH is ignored.
- Pixels with h≥SCREEN_WIDTH or v≥SCREEN_HEIGHT output 24'h000000 in every state.

## Timing
- Reset (rst_n_in low at a clk_in edge): state RUN, fill=0, tgt=0, fc=0, n=0, pipeline registers zero, pixel_out=0, settled_out=1, over_out=0.
- Reset asserted mid-FLASH or mid-OVER returns to RUN on the next edge.
- Pixel latency is exactly 2 cycles:
  - Stage 1 registers region compares: in_screen, in_bar, filled, in_glyph, tick.
  - Stage 2 registers the colour mux.
  - pixel_out for (h,v) presented at cycle t appears at t+2.
- The state/fill used for colour selection is the value at stage 1. A state change lands mid-line at most; no frame buffering.
- settled_out and over_out are registered and reflect state one cycle after the update edge.

## Configuration
- WALL_BAR_TICKS_EN defined: inside the bar, rows where (BAR_Y+BAR_HEIGHT−1−v) mod TICK_SPACING == 0 are drawn 24'h404040 in RUN and FLASH, overriding fill/background. TICK_SPACING must be a power of two; the modulo is a mask.
- WALL_BAR_TICKS_EN undefined: no tick logic is built; bar is fill/background only.

## Test plan
- Reset: hold rst_n_in low 3 cycles → pixel_out=0, settled_out=1, over_out=0. Then scan (40,679) → 24'h202020 two cycles later.
- Fill ramp: depth_in=10, FILL_STEP=4, three new_frame_in pulses → fill 4, 8, 10; settled_out high after the third. Pixel (60,670) filled and (60,669) background.
- Clamp: depth_in=1000 for 200 frames → fill=640 and (45,40) is FILL_COLOR. depth_in=0 then moves fill down by 4 per frame.
- Flash sequence: game_over_in with fill=100 → (45,679) is FFFFFF for 8 frames, FILL_COLOR for 8, and so on. After 48 frames over_out=1, and (640,500) is FFFFFF while (100,100) is 800000.
- Simultaneous: game_over_in+restart_in in RUN → FLASH with fill unchanged. Same pair in OVER → RUN with fill=0.
- Bounds/latency: hcount=1280, vcount=0 → pixel_out=0 at t+2. With WALL_BAR_TICKS_EN, fill=640 → row 679 reads 404040 and row 678 reads FILL_COLOR.
